rf_scoreboard: RTL and testbench

Parametrised register file for the single-cycle and pipelined CPU datapaths.
- Two asynchronous read ports and one synchronous write port.
- Optional hard-wired zero register.
- Per-entry pending (scoreboard) bits, set when an instruction issues and cleared on writeback, so the hazard unit can stall on RAW.
- Clearing is a sequential sweep (one entry per cycle), started by reset or by the Clr request, so the array can map to distributed RAM.

---
 rtl/rf_scoreboard.sv | 190 +++++++++++++++++++
 tb/tb_rf_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//   Register file for the CPU datapaths: two asynchronous read ports, one
//   synchronous write port, and a per-entry pending (scoreboard) bit the
//   hazard unit uses to stall on read-after-write.
//
//   The array is cleared by a sequential sweep (one entry per clock). Reset
//   starts the sweep, and so does Clr while idle. Because the array never
//   needs a parallel reset, it can map onto distributed RAM.
//
//   Optional feature, controlled by the macro RF_BYPASS_EN:
//     defined   - write-to-read forwarding. WD/En reach RDx/Pendx in the
//                 same cycle.
//     undefined - reads show a write only after the clock edge.
//
// Parameters
//   DATA_W    data width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   ZERO_REG  1 = entry 0 is a hard-wired zero register
//
// Ports
//   Clk       clock, rising edge
//   Reset     synchronous active-low reset
//   Clr       request a clear sweep (honoured only while Ready)
//   Ready     1 = idle, 0 = sweeping
//   R1/R2     read addresses       RD1/RD2   read data
//   Waddr     write address        WD        write data
//   En        write enable
//   Iss_en    mark Iss_addr pending
//   Iss_addr  destination register of the issuing instruction
//   Pend1/2   pending bits of R1/R2
// ---------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr,
  output logic              Ready,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [DATA_W-1:0] WD,
  input  logic              En,
  input  logic              Iss_en,
  input  logic [ADDR_W-1:0] Iss_addr,
  output logic              Pend1,
  output logic              Pend2
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = '0;
  localparam bit                HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic              w_idle;
  logic              w_wrOk;
  logic              w_issOk;
  logic              w_arrWe;
  logic [ADDR_W-1:0] w_arrAddr;
  logic [DATA_W-1:0] w_arrData;
  logic [DEPTH-1:0]  w_pendNext;

  assign w_idle = (r_state == IDLE);
  assign Ready  = w_idle;

  // A write or issue aimed at the hard-wired zero register is dropped.
  // These two terms only qualify the request. Gating by state happens where
  // they are used.
  assign w_wrOk  = En     && !(HAS_ZERO && (Waddr    == ZERO_IDX));
  assign w_issOk = Iss_en && !(HAS_ZERO && (Iss_addr == ZERO_IDX));

  // Select the single array write for this edge. While sweeping, the sweep
  // owns the port and any En is ignored. While idle, a normal write goes
  // through, even alongside Clr: the sweep that follows zeroes that entry
  // anyway. Nothing is written while Reset is low.
  always_comb begin
    w_arrWe   = 1'b0;
    w_arrAddr = r_idx;
    w_arrData = '0;
    if (Reset) begin
      if (!w_idle) begin
        w_arrWe = 1'b1;
      end else if (w_wrOk) begin
        w_arrWe   = 1'b1;
        w_arrAddr = Waddr;
        w_arrData = WD;
      end
    end
  end

  // The array has no reset, which keeps it mappable to distributed RAM.
  always_ff @(posedge Clk) begin
    if (w_arrWe) begin
      r_rf[w_arrAddr] <= w_arrData;
    end
  end

  // Next scoreboard value for an idle edge. The issue is applied after the
  // writeback clear, so a new producer keeps ownership of a register whose
  // older value is being written back in the same cycle.
  always_comb begin
    w_pendNext = r_pend;
    if (w_wrOk) begin
      w_pendNext[Waddr] = 1'b0;
    end
    if (w_issOk) begin
      w_pendNext[Iss_addr] = 1'b1;
    end
  end

  // Control FSM. Reset and an idle Clr both restart the sweep at index 0 and
  // drop every pending bit. During the sweep the index advances one entry
  // per edge and wraps to 0 on the last entry, which is also when the FSM
  // returns to IDLE. A Clr that arrives mid-sweep is ignored.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= SWEEP;
      r_idx   <= '0;
      r_pend  <= '0;
    end else if (r_state == SWEEP) begin
      r_idx <= r_idx + 1'b1;
      if (r_idx == LAST_IDX) begin
        r_state <= IDLE;
      end
    end else if (Clr) begin
      r_state <= SWEEP;
      r_idx   <= '0;
      r_pend  <= '0;
    end else begin
      r_pend <= w_pendNext;
    end
  end

  // Read port 1. The zero register and the sweep force zero outputs. The
  // sweep check comes last so it overrides any forwarded value.
  always_comb begin
    RD1   = r_rf[R1];
    Pend1 = r_pend[R1];
    if (HAS_ZERO && (R1 == ZERO_IDX)) begin
      RD1   = '0;
      Pend1 = 1'b0;
    end
`ifdef RF_BYPASS_EN
    if (w_idle && w_wrOk && (R1 == Waddr)) begin
      RD1   = WD;
      Pend1 = w_issOk && (Iss_addr == Waddr);
    end
`endif
    if (!w_idle) begin
      RD1   = '0;
      Pend1 = 1'b0;
    end
  end

  // Read port 2 follows the same rules as read port 1.
  always_comb begin
    RD2   = r_rf[R2];
    Pend2 = r_pend[R2];
    if (HAS_ZERO && (R2 == ZERO_IDX)) begin
      RD2   = '0;
      Pend2 = 1'b0;
    end
`ifdef RF_BYPASS_EN
    if (w_idle && w_wrOk && (R2 == Waddr)) begin
      RD2   = WD;
      Pend2 = w_issOk && (Iss_addr == Waddr);
    end
`endif
    if (!w_idle) begin
      RD2   = '0;
      Pend2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_rf_scoreboard
//   Directed bench for rf_scoreboard. Two instances share every input:
//   dut has the zero register enabled (ZERO_REG=1), and dutZ has it
//   disabled (ZERO_REG=0). Expected values are written out by hand at each
//   step. The bypass expectation follows RF_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_rf_scoreboard;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Clr;
  logic [4:0]  R1, R2, Waddr, Iss_addr;
  logic [31:0] WD;
  logic        En, Iss_en;

  logic        ready, pend1, pend2;
  logic [31:0] rd1, rd2;
  logic        readyZ, pend1Z, pend2Z;
  logic [31:0] rd1Z, rd2Z;

  int passCount  = 0;
  int totalCount = 0;
  int edgeCount;

  rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .Ready(ready),
    .R1(R1), .R2(R2), .RD1(rd1), .RD2(rd2),
    .Waddr(Waddr), .WD(WD), .En(En),
    .Iss_en(Iss_en), .Iss_addr(Iss_addr),
    .Pend1(pend1), .Pend2(pend2)
  );

  rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dutZ (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .Ready(readyZ),
    .R1(R1), .R2(R2), .RD1(rd1Z), .RD2(rd2Z),
    .Waddr(Waddr), .WD(WD), .En(En),
    .Iss_en(Iss_en), .Iss_addr(Iss_addr),
    .Pend1(pend1Z), .Pend2(pend2Z)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  // Inputs change here and outputs are sampled here.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Step the clock until Ready rises, capped at 100 edges, and record how
  // many edges that took in edgeCount.
  task automatic waitReady();
    edgeCount = 0;
    while (ready !== 1'b1 && edgeCount < 100) begin
      applyStimulus(1);
      edgeCount++;
    end
  endtask

  initial begin
    Reset = 1'b0; Clr = 1'b0; En = 1'b0; Iss_en = 1'b0;
    R1 = '0; R2 = '0; Waddr = '0; Iss_addr = '0; WD = '0;

    // Reset sweep: Ready stays low for exactly 32 edges after release.
    applyStimulus(2);
    checkOutput("resetReady", {31'b0, ready}, 32'd0);
    Reset = 1'b1;
    waitReady();
    checkOutput("resetSweepLen", edgeCount, 32'd32);
    checkOutput("resetReadyZ", {31'b0, readyZ}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      R1 = 5'(i);
      R2 = 5'(31 - i);
      #1;
      checkOutput($sformatf("clearRd1[%0d]", i), rd1, 32'd0);
      checkOutput($sformatf("clearRd2Z[%0d]", i), rd2Z, 32'd0);
      checkOutput($sformatf("clearPend[%0d]", i), {30'b0, pend1, pend2Z}, 32'd0);
    end

    // Write to entry 5, then try to write entry 0.
    En = 1'b1; Waddr = 5'd5; WD = 32'hDEADBEEF;
    applyStimulus(1);
    Waddr = 5'd0; WD = 32'h0000_1234;
    applyStimulus(1);
    En = 1'b0;
    R1 = 5'd5; R2 = 5'd0;
    #1;
    checkOutput("wrRd1", rd1, 32'hDEADBEEF);
    checkOutput("wrRd1Z", rd1Z, 32'hDEADBEEF);
    checkOutput("zeroRegRd2", rd2, 32'd0);
    checkOutput("noZeroRegRd2Z", rd2Z, 32'h0000_1234);

    // Scoreboard: issue, writeback plus a new issue, then writeback alone.
    Iss_en = 1'b1; Iss_addr = 5'd7; R1 = 5'd7;
    applyStimulus(1);
    checkOutput("issPend1", {31'b0, pend1}, 32'd1);
    En = 1'b1; Waddr = 5'd7; WD = 32'h0000_0077;
    applyStimulus(1);
    En = 1'b0; Iss_en = 1'b0;
    #1;
    checkOutput("setWinsPend1", {31'b0, pend1}, 32'd1);
    checkOutput("setWinsRd1", rd1, 32'h0000_0077);
    En = 1'b1; WD = 32'h0000_0088;
    applyStimulus(1);
    En = 1'b0;
    #1;
    checkOutput("wbClearPend1", {31'b0, pend1}, 32'd0);
    checkOutput("wbRd1", rd1, 32'h0000_0088);

    // Issuing to entry 0 is dropped only where the zero register exists.
    Iss_en = 1'b1; Iss_addr = 5'd0; R2 = 5'd0;
    applyStimulus(1);
    Iss_en = 1'b0;
    #1;
    checkOutput("zeroIssPend2", {31'b0, pend2}, 32'd0);
    checkOutput("zeroIssPend2Z", {31'b0, pend2Z}, 32'd1);

    // Forwarding: RD1 during the write cycle depends on RF_BYPASS_EN.
    R1 = 5'd9; En = 1'b1; Waddr = 5'd9; WD = 32'hA5A5A5A5;
    #1;
`ifdef RF_BYPASS_EN
    checkOutput("bypassRd1", rd1, 32'hA5A5A5A5);
`else
    checkOutput("noBypassRd1", rd1, 32'd0);
`endif
    checkOutput("bypassPend1", {31'b0, pend1}, 32'd0);
    applyStimulus(1);
    En = 1'b0;
    #1;
    checkOutput("postEdgeRd1", rd1, 32'hA5A5A5A5);

    // Clear sweep: a second Clr mid-sweep must not lengthen it.
    En = 1'b1; Waddr = 5'd3; WD = 32'h0000_0033;
    applyStimulus(1);
    Waddr = 5'd30; WD = 32'h0000_3030;
    applyStimulus(1);
    En = 1'b0; R1 = 5'd3; R2 = 5'd30;
    #1;
    checkOutput("preClrRd1", rd1, 32'h0000_0033);
    checkOutput("preClrRd2", rd2, 32'h0000_3030);
    Clr = 1'b1;
    applyStimulus(1);
    Clr = 1'b0;
    #1;
    checkOutput("clrReady", {31'b0, ready}, 32'd0);
    checkOutput("clrSweepRd1Forced0", rd1, 32'd0);
    edgeCount = 0;
    while (ready !== 1'b1 && edgeCount < 100) begin
      Clr = (edgeCount == 10);
      applyStimulus(1);
      edgeCount++;
    end
    Clr = 1'b0;
    checkOutput("clrSweepLen", edgeCount, 32'd32);
    #1;
    checkOutput("clrRd1", rd1, 32'd0);
    checkOutput("clrRd2", rd2, 32'd0);
    R1 = 5'd5; R2 = 5'd0;
    #1;
    checkOutput("clrRd1e5", rd1, 32'd0);
    checkOutput("clrPend2Z", {31'b0, pend2Z}, 32'd0);
    checkOutput("clrRd2Ze0", rd2Z, 32'd0);

    // Reset at sweep index 17 restarts the sweep. En and Iss_en stay
    // asserted throughout and must have no effect.
    En = 1'b1; Waddr = 5'd8; WD = 32'h0000_0808;
    applyStimulus(1);
    En = 1'b0;
    Clr = 1'b1;
    applyStimulus(1);
    Clr = 1'b0;
    applyStimulus(17);
    Reset = 1'b0;
    applyStimulus(2);
    checkOutput("midResetReady", {31'b0, ready}, 32'd0);
    Reset = 1'b1;
    En = 1'b1; Waddr = 5'd1; WD = 32'hFFFF_FFFF;
    Iss_en = 1'b1; Iss_addr = 5'd1;
    waitReady();
    En = 1'b0; Iss_en = 1'b0;
    checkOutput("midResetSweepLen", edgeCount, 32'd32);
    for (int i = 0; i < 32; i++) begin
      R1 = 5'(i);
      R2 = 5'(i);
      #1;
      checkOutput($sformatf("finalRd1[%0d]", i), rd1, 32'd0);
      checkOutput($sformatf("finalRd2Z[%0d]", i), rd2Z, 32'd0);
      checkOutput($sformatf("finalPend[%0d]", i), {30'b0, pend1, pend2Z}, 32'd0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
